// File: rtl/sram_1w1r_28x128_ctrl.sv
// Controller for a 28x128 1W1R SRAM macro: round-robin masked-write arbitration onto
// port 0, credit-limited read sequencing onto port 1 and an in-order response FIFO.
module sram_1w1r_28x128_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 128,
    parameter int NUM_WMASKS = 4,
    parameter int WORDS      = 28,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wa_valid,
    output logic                  wa_ready,
    input  logic [ADDR_WIDTH-1:0] wa_addr,
    input  logic [NUM_WMASKS-1:0] wa_mask,
    input  logic [DATA_WIDTH-1:0] wa_data,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [NUM_WMASKS-1:0] wb_mask,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic                  wr_err,
    output logic                  sram_csb0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);

    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(WORDS - 1);
    localparam logic [CW-1:0]         CREDIT_MAX = CW'(RSP_DEPTH);
    localparam logic [PW-1:0]         PTR_LAST   = PW'(RSP_DEPTH - 1);

    typedef struct packed {
        logic valid;
        logic err;
        logic bypass;
    } stage_t;

    logic                  wr_hold;
    logic                  prio_b;
    logic                  grant_a, grant_b;
    logic                  wr_fire, wr_in_range, wr_issue;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [NUM_WMASKS-1:0] wr_mask;
    logic [DATA_WIDTH-1:0] wr_data;

    logic                  rd_fire, rd_in_range, hazard, push, pop;
    logic [CW-1:0]         credits, fifo_count;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    stage_t                s1, s2;
    logic [DATA_WIDTH-1:0] fifo_data [RSP_DEPTH];
    logic [RSP_DEPTH-1:0]  fifo_err;

    assign wr_hold = 1'b0;

    // Grants already include valid; prio_b set means A was served last.
    assign grant_a     = wa_valid & (~wb_valid | ~prio_b);
    assign grant_b     = wb_valid & (~wa_valid | prio_b);
    assign wa_ready    = grant_a & ~wr_hold;
    assign wb_ready    = grant_b & ~wr_hold;
    assign wr_fire     = wa_ready | wb_ready;
    assign wr_addr     = wb_ready ? wb_addr : wa_addr;
    assign wr_mask     = wb_ready ? wb_mask : wa_mask;
    assign wr_data     = wb_ready ? wb_data : wa_data;
    assign wr_in_range = (wr_addr <= LAST_ADDR);
    assign wr_issue    = wr_fire & wr_in_range & (wr_mask != '0);

    assign rd_in_range = (rd_addr <= LAST_ADDR);
    assign hazard      = wr_fire & wr_in_range & (wr_addr == rd_addr);
    assign rsp_valid   = (fifo_count != '0);
    assign pop         = rsp_valid & rsp_ready;
    assign push        = s2.valid;
    // A same-cycle pop returns its credit immediately.
    assign rd_ready    = ((credits < CREDIT_MAX) | pop) & ~hazard;
    assign rd_fire     = rd_valid & rd_ready;
    assign rsp_data    = fifo_data[rd_ptr];
    assign rsp_err     = rsp_valid & fifo_err[rd_ptr];

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_b      <= 1'b0;
            wr_err      <= 1'b0;
            sram_csb0   <= 1'b1;
            sram_wmask0 <= '0;
            sram_addr0  <= '0;
            sram_din0   <= '0;
            sram_csb1   <= 1'b1;
            sram_addr1  <= '0;
            s1          <= '0;
            s2          <= '0;
            credits     <= '0;
        end else begin
            if (wr_fire) prio_b <= wa_ready;
            wr_err    <= wr_fire & ~wr_in_range;
            sram_csb0 <= ~wr_issue;
            if (wr_issue) begin
                sram_wmask0 <= wr_mask;
                sram_addr0  <= wr_addr;
                sram_din0   <= wr_data;
            end
            sram_csb1 <= ~(rd_fire & rd_in_range);
            if (rd_fire & rd_in_range) sram_addr1 <= rd_addr;
            s1      <= '{valid: rd_fire, err: rd_fire & ~rd_in_range, bypass: rd_fire & ~rd_in_range};
            s2      <= s1;
            credits <= credits + CW'(rd_fire) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    // NOTE: FIFO storage is deliberately not reset; the reset pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= s2.bypass ? '0 : sram_dout1;
            fifo_err[wr_ptr]  <= s2.err;
        end
    end

    fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (fifo_count == CREDIT_MAX)));

endmodule

// File: tb/tb_sram_1w1r_28x128_ctrl.sv
// Self-checking bench: behavioural macro, queue-based reference model checked every cycle,
// directed scenarios followed by a randomized phase.
module tb_sram_1w1r_28x128_ctrl;
    localparam int AW = 5, DW = 128, MW = 4, WORDS = 28, DEPTH = 4;

    logic clk = 1'b0, rst_n = 1'b0;
    logic wa_valid = 0, wb_valid = 0, rd_valid = 0, rsp_ready = 0;
    logic wa_ready, wb_ready, rd_ready, rsp_valid, rsp_err, wr_err;
    logic [AW-1:0] wa_addr = '0, wb_addr = '0, rd_addr = '0;
    logic [MW-1:0] wa_mask = '0, wb_mask = '0;
    logic [DW-1:0] wa_data = '0, wb_data = '0, rsp_data;
    logic sram_csb0, sram_csb1;
    logic [MW-1:0] sram_wmask0;
    logic [AW-1:0] sram_addr0, sram_addr1;
    logic [DW-1:0] sram_din0;
    logic [DW-1:0] sram_dout1 = '0;

    always #5 clk = ~clk;

    sram_1w1r_28x128_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(MW),
                            .WORDS(WORDS), .RSP_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .wa_valid(wa_valid), .wa_ready(wa_ready), .wa_addr(wa_addr), .wa_mask(wa_mask), .wa_data(wa_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_mask(wb_mask), .wb_data(wb_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .wr_err(wr_err),
        .sram_csb0(sram_csb0), .sram_wmask0(sram_wmask0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
        .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
    );

    // Macro model: capture on posedge, write and read on the following negedge.
    logic [DW-1:0] macro_mem [32];
    logic          m_csb0 = 1'b1, m_csb1 = 1'b1;
    logic [MW-1:0] m_wmask = '0;
    logic [AW-1:0] m_addr0 = '0, m_addr1 = '0;
    logic [DW-1:0] m_din = '0;

    always @(posedge clk) begin
        m_csb0  <= sram_csb0;
        m_wmask <= sram_wmask0;
        m_addr0 <= sram_addr0;
        m_din   <= sram_din0;
        m_csb1  <= sram_csb1;
        m_addr1 <= sram_addr1;
    end

    always @(negedge clk) begin
        if (m_csb0 === 1'b0)
            for (int l = 0; l < MW; l++)
                if (m_wmask[l]) macro_mem[m_addr0][l*32 +: 32] <= m_din[l*32 +: 32];
        if (m_csb1 === 1'b0) sram_dout1 <= macro_mem[m_addr1];
    end

    int n_checks = 0, n_fail = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: word array, round-robin pointer and a queue of outstanding reads.
    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            due;
    } rsp_t;

    rsp_t          exp_q[$];
    logic [DW-1:0] ref_mem [WORDS];
    logic          m_last_a;
    logic          exp_csb0, exp_csb1, exp_wr_err;
    logic [AW-1:0] exp_addr0, exp_addr1;
    logic [MW-1:0] exp_wmask0;
    logic [DW-1:0] exp_din0;
    int            cyc = 0, n_dut_rsp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic model_reset();
        exp_q.delete();
        m_last_a   = 1'b0;
        exp_csb0   = 1'b1;
        exp_csb1   = 1'b1;
        exp_wr_err = 1'b0;
    endtask

    task automatic monitor_cycle();
        logic ga, gb, wfire, pop, exp_valid, exp_rd_ready, rd_acc;
        logic [AW-1:0] wad;
        logic [MW-1:0] wm;
        logic [DW-1:0] wd;
        rsp_t e;
        check("csb0", sram_csb0, exp_csb0);
        if (!exp_csb0) begin
            check("addr0", sram_addr0, exp_addr0);
            check("wmask0", sram_wmask0, exp_wmask0);
            check("din0", sram_din0, exp_din0);
        end
        check("wr_err", wr_err, exp_wr_err);
        check("csb1", sram_csb1, exp_csb1);
        if (!exp_csb1) check("addr1", sram_addr1, exp_addr1);

        ga = wa_valid && (!wb_valid || !m_last_a);
        gb = wb_valid && !ga;
        check("wa_ready", wa_ready, ga);
        check("wb_ready", wb_ready, gb);
        wfire = ga || gb;
        wad = gb ? wb_addr : wa_addr;
        wm  = gb ? wb_mask : wa_mask;
        wd  = gb ? wb_data : wa_data;

        exp_valid = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
        check("rsp_valid", rsp_valid, exp_valid);
        if (exp_valid) begin
            check("rsp_data", rsp_data, exp_q[0].data);
            check("rsp_err", rsp_err, exp_q[0].err);
        end
        pop = exp_valid && rsp_ready;
        exp_rd_ready = ((exp_q.size() < DEPTH) || pop) && !(wfire && wad < WORDS && wad == rd_addr);
        check("rd_ready", rd_ready, exp_rd_ready);
        if (pop) void'(exp_q.pop_front());

        rd_acc = rd_valid && exp_rd_ready;
        if (rd_acc) begin
            e.err  = (rd_addr >= WORDS);
            e.data = e.err ? '0 : ref_mem[rd_addr];
            e.due  = cyc + 3;
            exp_q.push_back(e);
        end
        exp_csb1 = !(rd_acc && rd_addr < WORDS);
        if (!exp_csb1) exp_addr1 = rd_addr;

        if (wfire) begin
            m_last_a = ga;
            if (wad < WORDS)
                for (int l = 0; l < MW; l++)
                    if (wm[l]) ref_mem[wad][l*32 +: 32] = wd[l*32 +: 32];
        end
        exp_csb0 = !(wfire && wad < WORDS && wm != '0);
        if (!exp_csb0) begin
            exp_addr0  = wad;
            exp_wmask0 = wm;
            exp_din0   = wd;
        end
        exp_wr_err = wfire && (wad >= WORDS);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rsp_valid && rsp_ready) n_dut_rsp++;
            monitor_cycle();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_req(input bit use_b, input logic [AW-1:0] addr,
                          input logic [MW-1:0] mask, input logic [DW-1:0] data);
        bit acc = 0;
        if (use_b) begin
            wb_valid = 1; wb_addr = addr; wb_mask = mask; wb_data = data;
        end else begin
            wa_valid = 1; wa_addr = addr; wa_mask = mask; wa_data = data;
        end
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = use_b ? wb_ready : wa_ready;
            tick();
        end
        wa_valid = 0;
        wb_valid = 0;
        check("wr_accept", acc, 1'b1);
    endtask

    task automatic rd_req(input logic [AW-1:0] addr);
        bit acc = 0;
        rd_valid = 1;
        rd_addr  = addr;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = rd_ready;
            tick();
        end
        rd_valid = 0;
        check("rd_accept", acc, 1'b1);
    endtask

    task automatic wait_rsp(output logic [DW-1:0] data, output logic err);
        bit got = 0;
        data = '0;
        err  = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                got  = 1;
                data = rsp_data;
                err  = rsp_err;
            end
            tick();
        end
        check("rsp_arrive", got, 1'b1);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        @(negedge clk);
        check(tag, rsp_valid, 1'b0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end of the test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] d, first;
        logic          er;
        logic [DW-1:0] a_dat [8];
        logic [DW-1:0] b_dat [8];
        int            acc, npop, base, cnt;

        for (int i = 0; i < 32; i++) macro_mem[i] = '0;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
        model_reset();

        // Reset values
        tick(); tick(); tick();
        check("rst_csb0", sram_csb0, 1'b1);
        check("rst_csb1", sram_csb1, 1'b1);
        check("rst_wmask0", sram_wmask0, '0);
        check("rst_addr0", sram_addr0, '0);
        check("rst_din0", sram_din0, '0);
        check("rst_addr1", sram_addr1, '0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_wr_err", wr_err, 1'b0);
        rst_n = 1'b1;
        tick();

        // Fill and read back every legal word
        rsp_ready = 1;
        for (int a = 0; a < WORDS; a++) wr_req(0, AW'(a), 4'hF, {4{AW'(a), 27'h0}});
        base = n_dut_rsp;
        for (int a = 0; a < WORDS; a++) rd_req(AW'(a));
        wait_drain("fill_drain");
        check("fill_rsp_count", n_dut_rsp - base, WORDS);

        // Zero-mask B write leaves word 3 intact and makes A the next preferred requester
        wr_req(1, 5'd3, 4'h0, {DW{1'b1}});
        rd_req(5'd3);
        wait_rsp(d, er);
        check("zero_mask_word3", d, {4{5'd3, 27'h0}});

        // Arbitration: both valid for 8 cycles
        wa_valid = 1; wa_addr = 5'd1; wa_mask = 4'hF;
        wb_valid = 1; wb_addr = 5'd2; wb_mask = 4'hF;
        for (int i = 0; i < 8; i++) begin
            a_dat[i] = {$urandom, $urandom, $urandom, $urandom};
            b_dat[i] = {$urandom, $urandom, $urandom, $urandom};
            wa_data = a_dat[i];
            wb_data = b_dat[i];
            @(negedge clk);
            check("arb_grant_a", wa_ready, (i % 2) == 0);
            check("arb_grant_b", wb_ready, (i % 2) == 1);
            tick();
        end
        wa_valid = 0; wb_valid = 0;
        rd_req(5'd1);
        wait_rsp(d, er);
        check("arb_last_a", d, a_dat[6]);
        rd_req(5'd2);
        wait_rsp(d, er);
        check("arb_last_b", d, b_dat[7]);

        // Lane mask
        wr_req(0, 5'd5, 4'hF, {DW{1'b1}});
        wr_req(0, 5'd5, 4'b0101, '0);
        rd_req(5'd5);
        wait_rsp(d, er);
        check("lane_mask", d, 128'hFFFFFFFF_00000000_FFFFFFFF_00000000);
        wr_req(0, 5'd5, 4'h0, '0);
        rd_req(5'd5);
        wait_rsp(d, er);
        check("lane_mask_zero", d, 128'hFFFFFFFF_00000000_FFFFFFFF_00000000);

        // Read/write hazard on the same address
        wa_valid = 1; wa_addr = 5'd7; wa_mask = 4'hF; wa_data = {16{8'hA5}};
        rd_valid = 1; rd_addr = 5'd7;
        @(negedge clk);
        check("hazard_rd_ready", rd_ready, 1'b0);
        check("hazard_wa_ready", wa_ready, 1'b1);
        tick();
        wa_valid = 0;
        @(negedge clk);
        check("hazard_retry", rd_ready, 1'b1);
        tick();
        rd_valid = 0;
        wait_rsp(d, er);
        check("hazard_data", d, {16{8'hA5}});

        // Backpressure: credit limit
        rsp_ready = 0;
        acc = 0;
        rd_valid = 1; rd_addr = 5'd10;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rd_ready) acc++;
            tick();
            rd_addr = AW'(10 + acc);
        end
        check("bp_accepted", acc, DEPTH);
        @(negedge clk);
        check("bp_rd_ready_low", rd_ready, 1'b0);
        check("bp_rsp_valid", rsp_valid, 1'b1);
        tick();
        rsp_ready = 1;
        npop = 0;
        first = '0;
        for (int i = 0; i < 30 && (acc < 6 || npop < 6); i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                if (npop == 0) first = rsp_data;
                npop++;
            end
            if (rd_valid && rd_ready) acc++;
            tick();
            if (acc == 6) rd_valid = 0;
            else rd_addr = AW'(10 + acc);
        end
        rd_valid = 0;
        check("bp_total_accepted", acc, 6);
        check("bp_total_rsp", npop, 6);
        check("bp_first_data", first, {4{5'd10, 27'h0}});

        // Out-of-range write
        wr_req(0, 5'd30, 4'hF, {DW{1'b1}});
        @(negedge clk);
        check("oor_wr_err", wr_err, 1'b1);
        check("oor_wr_csb0", sram_csb0, 1'b1);
        tick();
        @(negedge clk);
        check("oor_wr_err_pulse", wr_err, 1'b0);
        tick();

        // Out-of-range read
        rd_req(5'd29);
        @(negedge clk);
        check("oor_rd_csb1", sram_csb1, 1'b1);
        tick();
        wait_rsp(d, er);
        check("oor_rd_data", d, '0);
        check("oor_rd_err", er, 1'b1);

        // Reset with two reads in flight
        rd_req(5'd1);
        rd_req(5'd2);
        rst_n = 1'b0;
        model_reset();
        tick(); tick();
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) cnt++;
            tick();
        end
        check("post_reset_rsp", cnt, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            wa_valid = ($urandom_range(0, 1) == 1);
            wa_addr  = AW'($urandom_range(0, 31));
            wa_mask  = MW'($urandom);
            wa_data  = {$urandom, $urandom, $urandom, $urandom};
            wb_valid = ($urandom_range(0, 1) == 1);
            wb_addr  = AW'($urandom_range(0, 31));
            wb_mask  = MW'($urandom);
            wb_data  = {$urandom, $urandom, $urandom, $urandom};
            rd_valid = ($urandom_range(0, 2) != 0);
            rd_addr  = ($urandom_range(0, 3) == 0) ? wa_addr : AW'($urandom_range(0, 31));
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        wa_valid = 0; wb_valid = 0; rd_valid = 0; rsp_ready = 1;
        wait_drain("random_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_1w1r_28x128_ctrl.md
# sram_1w1r_28x128_ctrl

Single-clock controller for the 28-word × 128-bit, 32-bit-lane 1W1R SRAM macro. It arbitrates two masked-write requesters onto write port 0 and sequences one read requester onto read port 1. Read data returns through a credit-limited response FIFO. It sits between the accelerator datapath and the macro, and it drives both macro clocks from `clk`.

## Interface
Parameters:
- `ADDR_WIDTH`, default 5: address width.
- `DATA_WIDTH`, default 128: word width.
- `NUM_WMASKS`, default 4: number of 32-bit write lanes.
- `WORDS`, default 28: number of legal addresses, 0..27.
- `RSP_DEPTH`, default 4: response FIFO depth, which is also the read credit limit.

Ports:
- `clk` in 1: single clock; the macro's `clk0` and `clk1` are tied to it at the wrapper.
- `rst_n` in 1: asynchronous, active-low reset.
- `wa_valid` / `wa_ready` in/out 1: write requester A handshake.
- `wa_addr` / `wa_mask` / `wa_data` in 5/4/128: write requester A address, lane mask and data.
- `wb_valid`, `wb_ready`, `wb_addr`, `wb_mask`, `wb_data`: write requester B, same widths as A.
- `rd_valid` / `rd_ready` in/out 1: read request handshake.
- `rd_addr` in 5: read address.
- `rsp_valid` / `rsp_ready` out/in 1: read response handshake.
- `rsp_data` out 128: read response data.
- `rsp_err` out 1: qualifies `rsp_data`; the response came from an out-of-range read.
- `wr_err` out 1: one-cycle pulse on acceptance of an out-of-range write.
- `sram_csb0` out 1, `sram_wmask0` out 4, `sram_addr0` out 5, `sram_din0` out 128: macro write port, all registered.
- `sram_csb1` out 1, `sram_addr1` out 5: macro read port, both registered.
- `sram_dout1` in 128: macro read data.

## Operation
- **Write arbitration.** Round-robin between A and B. The `ready` of the granted requester is combinational: `wx_ready = grant_x & ~wr_hold`.
  - When only one requester is valid, it wins.
  - When both are valid, the requester not served last wins. The pointer resets to favour A and updates only on an accepted write.
- **Write issue.** An accepted write with addr < 28 and mask ≠ 0 registers `sram_csb0=0`, `sram_wmask0=mask`, `sram_addr0`, `sram_din0` for exactly one cycle. Otherwise `sram_csb0=1`.
- **Zero-mask write.** Accepted and consumed. No macro access, no error.
- **Out-of-range write (addr ≥ 28).** Accepted. No macro access. `wr_err` is high for the following cycle.
- **Read credits.** `credits_used` = reads in flight + FIFO occupancy, range 0..RSP_DEPTH. `rd_ready = (credits_used < RSP_DEPTH) & ~hazard`.
- **Hazard.** Asserted when an in-range write is being accepted this cycle to the same address as `rd_addr`. The read stalls one cycle so the write lands first; the write is never stalled.
- **Read issue.** An accepted in-range read registers `sram_csb1=0` and `sram_addr1` for one cycle.
- **Out-of-range read.** Consumes a credit and issues no macro access. It still flows through the two-stage in-flight pipe and enters the FIFO with data 0 and `rsp_err=1`.
- **In-flight pipe.** Two stages, each holding valid, error and bypass bits. At stage 2 the controller samples `sram_dout1` (or substitutes 0 for a bypassed read) and pushes into the FIFO.
- **FIFO.** `rsp_valid` = FIFO not empty; pop on `rsp_valid & rsp_ready`. Credit accounting guarantees the FIFO never overflows. A push into a full FIFO is an assertion failure.
- **`wr_hold`.** Tied 0 in this revision; it is a reserved stall hook.

## Timing
- **Reset values (asynchronous on `rst_n` low).**
  - `sram_csb0 = sram_csb1 = 1`.
  - `sram_wmask0`, `sram_addr0`, `sram_din0`, `sram_addr1` = 0.
  - `rsp_valid = 0`, `rsp_err = 0`, `wr_err = 0`.
  - FIFO empty, credits 0, in-flight pipe cleared, arbiter pointer favours A.
- **Write latency.** Accept at edge N drives the macro port during cycle N→N+1. The macro captures at N+1 and writes on the following negedge.
- **Read latency.** Accept at edge N.
  - Macro captures at N+1.
  - Controller samples `sram_dout1` at N+2.
  - `rsp_valid` rises after N+2 when the FIFO was empty: 2 cycles accept-to-response.
- **Throughput.** One read per cycle is sustained while `rsp_ready` stays high.
- **Read-after-write visibility.** A read accepted at N+1 or later to an address written at N returns the new data.
- **Simultaneous credit events.** Pop and push in the same cycle leave occupancy unchanged. A pop frees a credit in the same cycle, so `rd_ready` may rise combinationally.
- **Reset mid-operation.** In-flight reads and FIFO contents are discarded. No response is produced for them after reset release.

## Test plan
- **Fill/readback.** Write A addr 0..27 with data {4{addr,27'h0}} and mask 4'hF. Read 0..27 with `rsp_ready=1`. Required: 28 responses, in order, matching, each 2 cycles after accept, `rsp_err=0`.
- **Arbitration.** A and B valid every cycle for 8 cycles, addresses 1 and 2. Required: grants alternate A,B,A,…; final contents are the last B data at 2 and the last A data at 1.
- **Lane mask.** Write 0xFFFF…F to addr 5 with mask 4'hF, then 0 to addr 5 with mask 4'b0101, then read 5. Required: data 0xFFFFFFFF_00000000_FFFFFFFF_00000000. A mask-0 write leaves the word unchanged.
- **Hazard.** Same-cycle write addr 7 = 0xA5…A5 and read addr 7. Required: `rd_ready=0` that cycle, read accepted next cycle, response = 0xA5…A5.
- **Backpressure.** `rsp_ready=0`, issue 6 reads. Required: exactly 4 accepted, then `rd_ready=0`. Raise `rsp_ready`: 4 responses in order, then the remaining 2 are accepted.
- **Out-of-range.** Write addr 30: required `wr_err` pulse and `sram_csb0` stays 1. Read addr 29: required response data 0 with `rsp_err=1`, `sram_csb1` stays 1. Assert `rst_n` low with 2 reads in flight: required no responses after release.
